// File: rtl/pipelined_kogge_stone_adder.sv
// pipelined_kogge_stone_adder: pipelined SIMD Kogge-Stone adder/subtractor with valid/ready flow control
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready = !out_valid | out_ready
//   a, b [WIDTH]          operands, lane k = [k*LW +: LW]
//   carry_in [LANES]      per-lane carry-in, ignored when sub = 1
//   sub                   1: a - b as a + ~b + 1 on every lane
//   out_valid / out_ready output handshake
//   sum [WIDTH]           per-lane result modulo 2^LW
//   carry_out [LANES]     lane carry out (1 = no borrow when subtracting)
//   overflow [LANES]      lane signed overflow
module pipelined_kogge_stone_adder #(
  parameter int WIDTH      = 32,
  parameter int LANES      = 1,
  parameter int PIPE_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [LANES-1:0] carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [LANES-1:0] carry_out,
  output logic [LANES-1:0] overflow
);
  localparam int LW = WIDTH / LANES;
  localparam int H  = $clog2(LW);

  // the whole pipe moves as one; a stalled output freezes every stage
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [WIDTH-1:0] bx, g0, p0;
  logic [LANES-1:0] c0;
  logic             v0;
  assign bx = sub ? ~b : b;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v0 <= 1'b0;
      g0 <= '0;
      p0 <= '0;
      c0 <= '0;
    end else if (adv) begin
      v0 <= in_valid;
      g0 <= a & bx;
      p0 <= a ^ bx;
      c0 <= sub ? '1 : carry_in;
    end

  // gi/pi: group generate/propagate entering level j; bi: bitwise propagate kept for the sum
  for (genvar j = 0; j < H; j++) begin : lv
    logic [WIDTH-1:0] gi, pi, bi, go, po;
    logic [LANES-1:0] ci;
    logic             vi;
    if (j == 0) begin : src
      assign gi = g0;
      assign pi = p0;
      assign bi = p0;
      assign ci = c0;
      assign vi = v0;
    end else if (j % PIPE_EVERY == 0) begin : src
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          gi <= '0;
          pi <= '0;
          bi <= '0;
          ci <= '0;
          vi <= 1'b0;
        end else if (adv) begin
          gi <= lv[j-1].go;
          pi <= lv[j-1].po;
          bi <= lv[j-1].bi;
          ci <= lv[j-1].ci;
          vi <= lv[j-1].vi;
        end
    end else begin : src
      assign gi = lv[j-1].go;
      assign pi = lv[j-1].po;
      assign bi = lv[j-1].bi;
      assign ci = lv[j-1].ci;
      assign vi = lv[j-1].vi;
    end
    // combining only within the lane keeps carries from crossing lane boundaries
    for (genvar i = 0; i < WIDTH; i++) begin : bt
      if (i % LW >= (1 << j)) begin : cmb
        assign go[i] = gi[i] | (pi[i] & gi[i-(1<<j)]);
        assign po[i] = pi[i] & pi[i-(1<<j)];
      end else begin : pas
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end
  end

  logic [WIDTH-1:0] gf, pf, bf, c;
  logic [LANES-1:0] cf, co_n, ov_n;
  logic             vf;
  assign gf = lv[H-1].go;
  assign pf = lv[H-1].po;
  assign bf = lv[H-1].bi;
  assign cf = lv[H-1].ci;
  assign vf = lv[H-1].vi;

  // carry into bit i is the lane prefix below i with the lane carry-in folded in
  for (genvar i = 0; i < WIDTH; i++) begin : cy
    if (i % LW == 0) begin : lo
      assign c[i] = cf[i/LW];
    end else begin : hi
      assign c[i] = gf[i-1] | (pf[i-1] & cf[i/LW]);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : ln
    assign co_n[k] = gf[k*LW+LW-1] | (pf[k*LW+LW-1] & cf[k]);
    assign ov_n[k] = c[k*LW+LW-1] ^ co_n[k];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= '0;
      overflow  <= '0;
    end else if (adv) begin
      out_valid <= vf;
      sum       <= bf ^ c;
      carry_out <= co_n;
      overflow  <= ov_n;
    end
endmodule

// File: tb/tb_pipelined_kogge_stone_adder.sv
// tb_pipelined_kogge_stone_adder: scoreboard bench over four adder configurations sharing one stimulus
module tb_pipelined_kogge_stone_adder;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  carry_in = '0;
  always #5 clk = ~clk;

  logic        ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3, c0, c1, c2, o0, o1, o2;
  logic [31:0] s0, s1, s2, s3;
  logic [3:0]  c3, o3, ir, ov;
  logic [31:0] sm [4];
  logic [3:0]  co [4], of [4];

  pipelined_kogge_stone_adder #(.WIDTH(32), .LANES(1), .PIPE_EVERY(1)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b), .carry_in(carry_in[0]),
    .sub(sub), .out_valid(ov0), .out_ready(out_ready), .sum(s0), .carry_out(c0), .overflow(o0));
  pipelined_kogge_stone_adder #(.WIDTH(32), .LANES(1), .PIPE_EVERY(2)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b), .carry_in(carry_in[0]),
    .sub(sub), .out_valid(ov1), .out_ready(out_ready), .sum(s1), .carry_out(c1), .overflow(o1));
  pipelined_kogge_stone_adder #(.WIDTH(32), .LANES(1), .PIPE_EVERY(5)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b), .carry_in(carry_in[0]),
    .sub(sub), .out_valid(ov2), .out_ready(out_ready), .sum(s2), .carry_out(c2), .overflow(o2));
  pipelined_kogge_stone_adder #(.WIDTH(32), .LANES(4), .PIPE_EVERY(1)) d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3), .a(a), .b(b), .carry_in(carry_in),
    .sub(sub), .out_valid(ov3), .out_ready(out_ready), .sum(s3), .carry_out(c3), .overflow(o3));

  always_comb begin
    ir = {ir3, ir2, ir1, ir0};
    ov = {ov3, ov2, ov1, ov0};
    sm[0] = s0;
    sm[1] = s1;
    sm[2] = s2;
    sm[3] = s3;
    co[0] = {3'b0, c0};
    co[1] = {3'b0, c1};
    co[2] = {3'b0, c2};
    co[3] = c3;
    of[0] = {3'b0, o0};
    of[1] = {3'b0, o1};
    of[2] = {3'b0, o2};
    of[3] = o3;
  end

  typedef struct { logic [31:0] s; logic [3:0] c, v; int t; } exp_t;
  typedef struct { logic [31:0] a, b; logic [3:0] ci; logic sb; int k; logic [31:0] s; logic [3:0] c, v; } vec_t;

  exp_t        q [4][$];
  int          lat [4] = '{6, 4, 2, 4};
  int          pops [4] = '{0, 0, 0, 0};
  logic [31:0] ls [4];
  logic [3:0]  lc [4], lv [4];
  logic [3:0]  acc;
  int          cyc = 0, pass_n = 0, tot_n = 0;
  bit          chk_lat = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // independent reference: plain per-lane arithmetic, overflow from operand/result signs
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] ci,
                                 input logic sb, input int lanes, input int t);
    exp_t e;
    int lw;
    longint unsigned m, xa, yb, r;
    lw = 32 / lanes;
    m = (64'd1 << lw) - 64'd1;
    e.s = '0;
    e.c = '0;
    e.v = '0;
    e.t = t;
    for (int k = 0; k < lanes; k++) begin
      xa = (64'(x) >> (k * lw)) & m;
      yb = (64'(y) >> (k * lw)) & m;
      if (sb) yb = ~yb & m;
      r = xa + yb + {63'd0, sb | ci[k]};
      e.s = e.s | 32'((r & m) << (k * lw));
      e.c[k] = r[lw];
      e.v[k] = (xa[lw-1] == yb[lw-1]) && (r[lw-1] != xa[lw-1]);
    end
    return e;
  endfunction

  function automatic int busy();
    return q[0].size() + q[1].size() + q[2].size() + q[3].size();
  endfunction

  // one clock cycle: drive at posedge+1, score at negedge, return at next posedge+1
  task automatic step(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [3:0] ci,
                      input logic sb, input logic r);
    exp_t e;
    in_valid = v;
    a = x;
    b = y;
    carry_in = ci;
    sub = sb;
    out_ready = r;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() == 0) chk($sformatf("idle_valid_d%0d", k), 64'(ov[k]), 64'd0);
      else if (ov[k]) begin
        e = q[k][0];
        chk($sformatf("sum_d%0d", k), 64'(sm[k]), 64'(e.s));
        chk($sformatf("carry_d%0d", k), 64'(co[k]), 64'(e.c));
        chk($sformatf("ovf_d%0d", k), 64'(of[k]), 64'(e.v));
        if (out_ready) begin
          void'(q[k].pop_front());
          if (chk_lat) chk($sformatf("latency_d%0d", k), 64'(cyc - e.t), 64'(lat[k]));
          pops[k]++;
          ls[k] = sm[k];
          lc[k] = co[k];
          lv[k] = of[k];
        end
      end
      acc[k] = in_valid && ir[k];
      if (acc[k]) q[k].push_back(model(a, b, carry_in, sub, k == 3 ? 4 : 1, cyc));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && busy() != 0; n++) step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("drain_empty", 64'(busy()), 64'd0);
  endtask

  vec_t tbl [7];
  initial begin
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 4'b0000, 1'b0, 0, 32'h00000000, 4'b0001, 4'b0000};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 4'b0000, 1'b0, 0, 32'h80000000, 4'b0000, 4'b0001};
    tbl[2] = '{32'h00000005, 32'h00000007, 4'b0000, 1'b1, 0, 32'hFFFFFFFE, 4'b0000, 4'b0000};
    tbl[3] = '{32'h80000000, 32'h00000001, 4'b0000, 1'b1, 0, 32'h7FFFFFFF, 4'b0001, 4'b0001};
    tbl[4] = '{32'h12345678, 32'h0FEDCBA9, 4'b0001, 1'b0, 0, 32'h22222222, 4'b0000, 4'b0000};
    tbl[5] = '{32'h01FF80FF, 32'h01018001, 4'b0001, 1'b0, 3, 32'h02000001, 4'b0111, 4'b0010};
    tbl[6] = '{32'h10007F05, 32'h0101FF07, 4'b1111, 1'b1, 3, 32'h0FFF80FE, 4'b1000, 4'b0010};
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_valid_d%0d", k), 64'(ov[k]), 64'd0);
      chk($sformatf("reset_sum_d%0d", k), 64'(sm[k]), 64'd0);
    end
    rst_n = 1'b1;
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);

    chk_lat = 1;
    for (int i = 0; i < 7; i++) begin
      int k, start;
      k = tbl[i].k;
      start = pops[k];
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb, 1'b1);
      for (int n = 0; n < 12 && pops[k] == start; n++) step(1'b0, '0, '0, '0, 1'b0, 1'b1);
      chk($sformatf("vec%0d_done", i), 64'(pops[k] - start), 64'd1);
      chk($sformatf("vec%0d_sum", i), 64'(ls[k]), 64'(tbl[i].s));
      chk($sformatf("vec%0d_carry", i), 64'(lc[k]), 64'(tbl[i].c));
      chk($sformatf("vec%0d_ovf", i), 64'(lv[k]), 64'(tbl[i].v));
      drain();
    end

    for (int n = 0; n < 10; n++) begin
      step(1'b1, $urandom, $urandom, 4'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1);
      chk("b2b_accept", 64'(acc), 64'hF);
    end
    drain();

    chk_lat = 0;
    for (int n = 0; n < 20; n++) begin
      logic [31:0] x, y;
      logic [3:0]  ci;
      logic        sb;
      int          t;
      x = $urandom;
      y = $urandom;
      ci = 4'($urandom);
      sb = 1'($urandom_range(0, 3) == 0);
      t = 0;
      do begin
        step(1'b1, x, y, ci, sb, 1'($urandom_range(0, 2) != 0));
        t++;
      end while (!acc[0] && t < 50);
      chk("bp_accept_d0", 64'(acc[0]), 64'd1);
      if (($urandom_range(0, 2)) == 0) step(1'b0, '0, '0, '0, 1'b0, 1'($urandom_range(0, 1)));
    end
    drain();

    for (int n = 0; n < 3; n++) step(1'b1, $urandom, $urandom, 4'($urandom), 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("arst_valid_d%0d", k), 64'(ov[k]), 64'd0);
      chk($sformatf("arst_sum_d%0d", k), 64'(sm[k]), 64'd0);
      chk($sformatf("arst_carry_d%0d", k), 64'(co[k]), 64'd0);
      q[k].delete();
    end
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    rst_n = 1'b1;
    chk_lat = 1;
    step(1'b1, 32'h0000FFFF, 32'h00000001, 4'b0000, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
